// File: rtl/dds_lut_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dds_lut_pkg : shared types and constants for the DDS LUT ctrl   |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package dds_lut_pkg;

    localparam int LUT_DEPTH    = 512;
    localparam int DEF_INIT_VAL = 0;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic dds;
        logic host;
    } rd_tag_t;

endpackage : dds_lut_pkg
`default_nettype wire

// File: rtl/dds_lut_rd_arb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dds_lut_rd_arb : LSRAM read-port arbiter, starvation counter    |
// | and two-stage read tag pipeline.               rev 1.0          |
// +-----------------------------------------------------------------+
module dds_lut_rd_arb
    import dds_lut_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 18,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              dds_en,
    input  logic [ADDR_W-1:0] dds_addr,
    input  logic              host_rreq,
    input  logic [ADDR_W-1:0] host_raddr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_rdb,
    output logic              host_rack,
    output logic              dds_valid,
    output logic [DATA_W-1:0] dds_data,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             host_pend;
    logic             steal;
    logic             dds_grant;
    logic             host_grant;
    rd_tag_t          tag_s1;
    rd_tag_t          tag_s2;

    // A saturated counter lets the host take exactly one DDS slot.
    always_comb begin
        host_pend  = run & host_rreq;
        steal      = host_pend & (starve_cnt == CNT_MAX);
        dds_grant  = run & dds_en & ~steal;
        host_grant = host_pend & (~dds_en | steal);
        ram_rdb    = dds_grant | host_grant;
        ram_raddr  = '0;
        if (host_grant) begin
            ram_raddr = host_raddr;
        end else if (dds_grant) begin
            ram_raddr = dds_addr;
        end
    end

    assign host_rack   = host_grant;
    assign dds_valid   = tag_s2.dds;
    assign host_rvalid = tag_s2.host;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!run || host_grant) begin
            starve_cnt <= '0;
        end else if (host_pend && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Stage 1 tags the cycle RAM_DO is valid; stage 2 drives the valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_s1     <= '0;
            tag_s2     <= '0;
            dds_data   <= '0;
            host_rdata <= '0;
        end else begin
            tag_s1 <= '{dds: dds_grant, host: host_grant};
            tag_s2 <= tag_s1;
            if (tag_s1.dds) begin
                dds_data <= rd_data;
            end
            if (tag_s1.host) begin
                host_rdata <= rd_data;
            end
        end
    end

endmodule : dds_lut_rd_arb
`default_nettype wire

// File: rtl/dds_lut_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dds_lut_ctrl : clear sweep, write mux and collision forwarding  |
// | for the CoreDDS 512x18 LSRAM lookup table.     rev 1.0          |
// +-----------------------------------------------------------------+
module dds_lut_ctrl
    import dds_lut_pkg::*;
#(
    parameter int              ADDR_W     = 9,
    parameter int              DATA_W     = 18,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(DEF_INIT_VAL),
    parameter int              STARVE_MAX = 15
) (
    input  logic              CLK,
    input  logic              NGRST,
    input  logic              CLR_REQ,
    output logic              INIT_DONE,
    input  logic              DDS_EN,
    input  logic [ADDR_W-1:0] DDS_ADDR,
    output logic              DDS_VALID,
    output logic [DATA_W-1:0] DDS_DATA,
    input  logic              HOST_WREQ,
    input  logic [ADDR_W-1:0] HOST_WADDR,
    input  logic [DATA_W-1:0] HOST_WDATA,
    output logic              HOST_WACK,
    input  logic              HOST_RREQ,
    input  logic [ADDR_W-1:0] HOST_RADDR,
    output logic              HOST_RACK,
    output logic              HOST_RVALID,
    output logic [DATA_W-1:0] HOST_RDATA,
    output logic [DATA_W-1:0] RAM_DI,
    output logic [ADDR_W-1:0] RAM_WADDR,
    output logic              RAM_WRB,
    output logic [ADDR_W-1:0] RAM_RADDR,
    output logic              RAM_RDB,
    input  logic [DATA_W-1:0] RAM_DO
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LUT_DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] rd_data;

    assign run       = (state == ST_RUN);
    assign INIT_DONE = run;

    // The clear counter wraps to 0 after the last word, ready for the next sweep.
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            state    <= ST_INIT;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                clr_addr <= clr_addr + 1'b1;
            end else begin
                clr_addr <= '0;
            end
        end
    end

    // NGRST gates the sweep write so nothing is written while reset is held.
    always_comb begin
        state_nxt = state;
        RAM_WRB   = 1'b0;
        RAM_WADDR = clr_addr;
        RAM_DI    = INIT_VAL;
        HOST_WACK = 1'b0;
        case (state)
            ST_INIT: begin
                RAM_WRB = NGRST;
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                RAM_WADDR = HOST_WADDR;
                RAM_DI    = HOST_WDATA;
                RAM_WRB   = HOST_WREQ;
                HOST_WACK = HOST_WREQ;
                if (CLR_REQ) begin
                    state_nxt = ST_INIT;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // LSRAM returns old data on a same-address write/read; substitute the new word.
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit  <= RAM_WRB & RAM_RDB & (RAM_WADDR == RAM_RADDR);
            fwd_data <= RAM_DI;
        end
    end

    assign rd_data = fwd_hit ? fwd_data : RAM_DO;

    dds_lut_rd_arb #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_rd_arb (
        .clk         (CLK),
        .rst_n       (NGRST),
        .run         (run),
        .dds_en      (DDS_EN),
        .dds_addr    (DDS_ADDR),
        .host_rreq   (HOST_RREQ),
        .host_raddr  (HOST_RADDR),
        .rd_data     (rd_data),
        .ram_raddr   (RAM_RADDR),
        .ram_rdb     (RAM_RDB),
        .host_rack   (HOST_RACK),
        .dds_valid   (DDS_VALID),
        .dds_data    (DDS_DATA),
        .host_rvalid (HOST_RVALID),
        .host_rdata  (HOST_RDATA)
    );

endmodule : dds_lut_ctrl
`default_nettype wire

// File: tb/tb_dds_lut_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_dds_lut_ctrl : self-checking bench with LSRAM model and a    |
// | behavioural table/latency reference.           rev 1.0          |
// +-----------------------------------------------------------------+
module tb_dds_lut_ctrl;

    localparam int AW = 9;
    localparam int DW = 18;
    localparam int SMAX = 15;

    logic          CLK = 1'b0;
    logic          NGRST;
    logic          CLR_REQ;
    logic          INIT_DONE;
    logic          DDS_EN;
    logic [AW-1:0] DDS_ADDR;
    logic          DDS_VALID;
    logic [DW-1:0] DDS_DATA;
    logic          HOST_WREQ;
    logic [AW-1:0] HOST_WADDR;
    logic [DW-1:0] HOST_WDATA;
    logic          HOST_WACK;
    logic          HOST_RREQ;
    logic [AW-1:0] HOST_RADDR;
    logic          HOST_RACK;
    logic          HOST_RVALID;
    logic [DW-1:0] HOST_RDATA;
    logic [DW-1:0] RAM_DI;
    logic [AW-1:0] RAM_WADDR;
    logic          RAM_WRB;
    logic [AW-1:0] RAM_RADDR;
    logic          RAM_RDB;
    logic [DW-1:0] RAM_DO;

    always #5 CLK = ~CLK;

    dds_lut_ctrl dut (
        .CLK(CLK), .NGRST(NGRST), .CLR_REQ(CLR_REQ), .INIT_DONE(INIT_DONE),
        .DDS_EN(DDS_EN), .DDS_ADDR(DDS_ADDR), .DDS_VALID(DDS_VALID), .DDS_DATA(DDS_DATA),
        .HOST_WREQ(HOST_WREQ), .HOST_WADDR(HOST_WADDR), .HOST_WDATA(HOST_WDATA),
        .HOST_WACK(HOST_WACK), .HOST_RREQ(HOST_RREQ), .HOST_RADDR(HOST_RADDR),
        .HOST_RACK(HOST_RACK), .HOST_RVALID(HOST_RVALID), .HOST_RDATA(HOST_RDATA),
        .RAM_DI(RAM_DI), .RAM_WADDR(RAM_WADDR), .RAM_WRB(RAM_WRB),
        .RAM_RADDR(RAM_RADDR), .RAM_RDB(RAM_RDB), .RAM_DO(RAM_DO)
    );

    // LSRAM: registered read returning the pre-write word on a collision.
    logic [DW-1:0] ram [0:511];
    always @(posedge CLK) begin
        if (RAM_RDB) RAM_DO <= ram[RAM_RADDR];
        if (RAM_WRB) ram[RAM_WADDR] <= RAM_DI;
    end

    // Reference: table contents, mode, host wait and a two-deep result delay line.
    logic [DW-1:0] mem [0:511];
    bit            run;
    int            sweep_idx;
    int            hwait;
    bit            p1_dv, p1_hv, p2_dv, p2_hv;
    logic [DW-1:0] p1_d, p2_d, exp_dds, exp_host;
    bit            obs_rack, obs_done;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run = 0; sweep_idx = 0; hwait = 0;
        p1_dv = 0; p1_hv = 0; p2_dv = 0; p2_hv = 0;
        p1_d = '0; p2_d = '0; exp_dds = '0; exp_host = '0;
    endtask

    // One clock cycle: check at the falling edge, advance the model, release acked requests.
    task automatic tick();
        bit            wack, wrb, pend, hgnt, dgnt;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        @(negedge CLK);
        wack = run && HOST_WREQ;
        wrb  = !run || wack;
        wa   = run ? HOST_WADDR : AW'(sweep_idx);
        wd   = run ? HOST_WDATA : '0;
        pend = run && HOST_RREQ;
        hgnt = pend && (!DDS_EN || hwait == SMAX);
        dgnt = run && DDS_EN && !hgnt;
        ra   = hgnt ? HOST_RADDR : DDS_ADDR;
        chk("init_done", INIT_DONE, run);
        chk("host_wack", HOST_WACK, wack);
        chk("ram_wrb", RAM_WRB, wrb);
        if (wrb) begin
            chk("ram_waddr", RAM_WADDR, wa);
            chk("ram_di", RAM_DI, wd);
        end
        chk("host_rack", HOST_RACK, hgnt);
        chk("ram_rdb", RAM_RDB, hgnt || dgnt);
        if (hgnt || dgnt) chk("ram_raddr", RAM_RADDR, ra);
        if (p2_dv) exp_dds = p2_d;
        if (p2_hv) exp_host = p2_d;
        chk("dds_valid", DDS_VALID, p2_dv);
        chk("dds_data", DDS_DATA, exp_dds);
        chk("host_rvalid", HOST_RVALID, p2_hv);
        chk("host_rdata", HOST_RDATA, exp_host);
        obs_rack = HOST_RACK;
        obs_done = INIT_DONE;
        if (wrb) mem[wa] = wd;
        p2_dv = p1_dv; p2_hv = p1_hv; p2_d = p1_d;
        p1_dv = dgnt; p1_hv = hgnt; p1_d = mem[ra];
        if (!run || hgnt) hwait = 0;
        else if (pend && hwait < SMAX) hwait++;
        if (!run) begin
            sweep_idx++;
            if (sweep_idx == 512) begin
                run = 1;
                sweep_idx = 0;
            end
        end else if (CLR_REQ) begin
            run = 0;
        end
        @(posedge CLK);
        #1;
        CLR_REQ = 1'b0;
        if (wack) HOST_WREQ = 1'b0;
        if (hgnt) HOST_RREQ = 1'b0;
    endtask

    task automatic do_reset();
        NGRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            DDS_ADDR = AW'($urandom);
            @(negedge CLK);
            chk("rst_init_done", INIT_DONE, 0);
            chk("rst_dds_valid", DDS_VALID, 0);
            chk("rst_wack", HOST_WACK, 0);
            chk("rst_rack", HOST_RACK, 0);
            chk("rst_rvalid", HOST_RVALID, 0);
            chk("rst_wrb", RAM_WRB, 0);
            chk("rst_rdb", RAM_RDB, 0);
            chk("rst_dds_data", DDS_DATA, 0);
            chk("rst_host_rdata", HOST_RDATA, 0);
            chk("rst_ram_di", RAM_DI, 0);
            chk("rst_waddr", RAM_WADDR, 0);
            chk("rst_raddr", RAM_RADDR, 0);
        end
        @(posedge CLK);
        #1;
        NGRST = 1'b1;
        model_reset();
    endtask

    task automatic idle();
        DDS_EN = 1'b0;
        CLR_REQ = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        NGRST = 1'b0; CLR_REQ = 1'b0; DDS_EN = 1'b0; DDS_ADDR = '0;
        HOST_WREQ = 1'b0; HOST_WADDR = '0; HOST_WDATA = '0;
        HOST_RREQ = 1'b0; HOST_RADDR = '0;
        model_reset();

        // Reset, partial sweep, reset again mid-sweep, then a full clear.
        do_reset();
        for (int i = 0; i < 200; i++) tick();
        do_reset();
        n = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (obs_done) break;
            n++;
        end
        chk("sweep_len", n, 512);
        for (int i = 0; i < 5; i++) tick();

        // Host write then readback.
        HOST_WREQ = 1'b1; HOST_WADDR = 9'h1F5; HOST_WDATA = 18'h2ABCD;
        tick();
        HOST_RREQ = 1'b1; HOST_RADDR = 9'h1F5;
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("rd_1f5", HOST_RDATA, 18'h2ABCD);

        // Ramp load then DDS sweep at full rate.
        for (int a = 0; a < 512; a++) begin
            HOST_WREQ = 1'b1; HOST_WADDR = AW'(a); HOST_WDATA = DW'(a);
            tick();
        end
        for (int a = 0; a < 512; a++) begin
            DDS_EN = 1'b1; DDS_ADDR = AW'(a);
            tick();
        end
        idle();
        tick(); tick();
        chk("sweep_last", DDS_DATA, 18'h1FF);

        // Starvation: host read under continuous DDS traffic.
        HOST_RREQ = 1'b1; HOST_RADDR = 9'h0A5;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            DDS_EN = 1'b1; DDS_ADDR = AW'($urandom);
            tick();
            if (obs_rack) break;
            n++;
        end
        chk("starve_wait", n, SMAX);
        for (int i = 0; i < 4; i++) begin
            DDS_ADDR = AW'($urandom);
            tick();
        end
        idle();
        tick(); tick();
        chk("starve_rdata", HOST_RDATA, 18'h0A5);

        // Same-cycle write and DDS read of address 7.
        HOST_WREQ = 1'b1; HOST_WADDR = 9'd7; HOST_WDATA = 18'h15555;
        DDS_EN = 1'b1; DDS_ADDR = 9'd7;
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("collision", DDS_DATA, 18'h15555);

        // Randomised mixed traffic.
        for (int i = 0; i < 1500; i++) begin
            DDS_EN = ($urandom_range(3) != 0);
            DDS_ADDR = AW'($urandom);
            if (!HOST_WREQ && $urandom_range(9) < 3) begin
                HOST_WREQ = 1'b1;
                HOST_WADDR = ($urandom_range(3) == 0) ? DDS_ADDR : AW'($urandom);
                HOST_WDATA = DW'($urandom);
            end
            if (!HOST_RREQ && $urandom_range(9) < 2) begin
                HOST_RREQ = 1'b1;
                HOST_RADDR = AW'($urandom);
            end
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Clear request during DDS traffic; a host write waits through the sweep.
        DDS_EN = 1'b1; DDS_ADDR = 9'd5;
        tick();
        DDS_ADDR = 9'd6; CLR_REQ = 1'b1;
        tick();
        DDS_ADDR = 9'd9;
        HOST_WREQ = 1'b1; HOST_WADDR = 9'h010; HOST_WDATA = 18'h3FFFF;
        n = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (obs_done) break;
            n++;
        end
        chk("clr_len", n, 512);
        idle();
        tick();
        HOST_RREQ = 1'b1; HOST_RADDR = 9'h1F5;
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("clr_rd_1f5", HOST_RDATA, 0);
        HOST_RREQ = 1'b1; HOST_RADDR = 9'h010;
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("held_write", HOST_RDATA, 18'h3FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dds_lut_ctrl
`default_nettype wire
